mxu_row_drain: RTL and testbench
================================

MXU_ROW_DRAIN -- requirements
Module: mxu_row_drain

Interface
REQ-001 Parameter ROWS, default 16, number of result rows captured per tile; SHALL be even and >= 2.
REQ-002 Parameter COLS, default 16, elements per row, >= 1.
REQ-003 Parameter ACC_W, default 16, signed accumulator element width, >= 8.
REQ-004 Port clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 Port rst  input  1  reset: asynchronous, active-high.
REQ-006 Port in_vld  input  1  a result tile is offered on in_data.
REQ-007 Port in_rdy  output  1  block accepts a tile; SHALL be high exactly when the FSM is in IDLE.
REQ-008 Port in_data  input  ROWS*COLS*ACC_W  tile; row r at [r*COLS*ACC_W +: COLS*ACC_W]; element c of a row at [c*ACC_W +: ACC_W].
REQ-009 Port in_relu  input  1  tile mode: apply ReLU.
REQ-010 Port in_pool2  input  1  tile mode: 2:1 row max-pool.
REQ-011 Port clr  input  1  synchronous abort of the current tile.
REQ-012 Port out_vld  output  1  output row valid.
REQ-013 Port out_rdy  input  1  consumer accepts the output row.
REQ-014 Port out_wide_data  output  COLS*ACC_W  processed row at full width.
REQ-015 Port out_int8_data  output  COLS*8  processed row with each element saturated to signed 8-bit.
REQ-016 Port out_row_idx  output  $clog2(ROWS)  index of the current output beat.
REQ-017 Port out_last  output  1  current beat is the final beat of the tile.
REQ-018 Port busy  output  1  FSM is not IDLE.

Function
REQ-019 The FSM SHALL have two states: IDLE and DRAIN.
REQ-020 A capture occurs when in_vld && in_rdy; it SHALL register in_data, in_relu and in_pool2, clear the beat counter, and move the FSM to DRAIN.
REQ-021 out_vld SHALL rise in the cycle after the capture; latency from capture to first beat is 1 cycle.
REQ-022 The number of beats per tile SHALL be ROWS with pool2=0, and ROWS/2 with pool2=1.
REQ-023 Beat k SHALL output row k when pool2=0, and the elementwise signed max of rows 2k and 2k+1 when pool2=1.
REQ-024 When relu=1, negative elements SHALL be replaced by 0 before the max and before saturation.
REQ-025 Each out_int8_data element SHALL be 127 if the signed value > 127, -128 if < -128, else the low 8 bits.
REQ-026 A beat completes on out_vld && out_rdy, and the beat counter SHALL then increment by 1.
REQ-027 While out_vld=1 && out_rdy=0, all out_* signals SHALL hold stable.
REQ-028 out_last SHALL equal (beat counter == beats-1) while out_vld=1, and SHALL be 0 otherwise.
REQ-029 When the last beat completes, the FSM SHALL return to IDLE and out_vld SHALL fall in the next cycle; the next capture SHALL be possible in that same next cycle.
REQ-030 The beat counter SHALL never wrap: no beat with index >= beats is ever presented.
REQ-031 clr=1 SHALL force IDLE and clear out_vld, the beat counter and busy in the next cycle, regardless of state.
REQ-032 clr SHALL take priority over a simultaneous capture (tile discarded) and over a simultaneous beat completion (the beat still counts as transferred for the consumer).
REQ-033 in_vld during DRAIN SHALL be ignored because in_rdy=0; an upstream holding in_vld high is served on return to IDLE.
REQ-034 Mode inputs SHALL only be sampled at capture; changes during DRAIN SHALL have no effect.
REQ-035 When out_vld=0, out_wide_data and out_int8_data SHALL be 0.

Reset
REQ-036 While rst is high, and immediately after its release: state=IDLE, in_rdy=1, busy=0, out_vld=0, out_last=0, out_row_idx=0, out data=0, tile buffer and mode registers=0.
REQ-037 Asserting rst mid-DRAIN SHALL abandon the tile asynchronously, with no further beats after release.

Verification
REQ-038 ROWS=4, COLS=2, plain tile rows {1,2},{3,4},{5,6},{7,8}, out_rdy=1 -> 4 beats in consecutive cycles starting 1 cycle after capture, out_last only on idx 3, in_rdy high the cycle after.
REQ-039 Element values 300 and -200 with relu=0 -> wide 300/-200, int8 127/-128; same tile with relu=1 -> wide 300/0, int8 127/0.
REQ-040 pool2=1, rows {-5,9},{4,-1},{0,0},{-3,-7} -> 2 beats: {4,9}, then {0,0} with out_last=1.
REQ-041 out_rdy toggled 1,0,0,1 during the drain -> beat 1 held stable for 3 cycles, no beat lost or duplicated, total 4 beats.
REQ-042 clr asserted at beat 2, with in_vld asserted simultaneously at the return to IDLE -> out_vld=0 the next cycle; clr-cycle capture discarded; next tile drains from idx 0.
REQ-043 rst pulsed mid-DRAIN -> all outputs reach reset values within the same cycle; no beats after release until a new capture.

Source files
------------

// File: rtl/mxu_row_drain.sv
// -----------------------------------------------------------------------------
// mxu_row_drain
//
// Captures one matrix-unit result tile (ROWS x COLS signed accumulators) and
// drains it to a downstream consumer one row per beat over a valid/ready
// handshake. Each tile carries two mode bits sampled at capture:
//   relu  : negative elements are replaced by 0
//   pool2 : adjacent row pairs (2k, 2k+1) are reduced by elementwise signed max,
//           halving the number of beats
// Every beat is presented both at full accumulator width and saturated to
// signed 8-bit.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_vld / in_rdy   tile handshake; in_rdy is high only in IDLE
//   in_data           tile, row r at [r*COLS*ACC_W +: COLS*ACC_W]
//   in_relu, in_pool2 tile mode, sampled at capture only
//   clr               synchronous abort of the current tile
//   out_vld / out_rdy row handshake
//   out_wide_data     processed row, ACC_W bits per element (0 when idle)
//   out_int8_data     processed row, 8 bits per element (0 when idle)
//   out_row_idx       index of the current beat
//   out_last          current beat is the final beat of the tile
//   busy              a tile is being drained
//
// State table
//   state   | meaning
//   S_IDLE  | no tile held; in_rdy=1, waiting for in_vld
//   S_DRAIN | tile held; presenting beat cnt_q until the last beat completes
// -----------------------------------------------------------------------------
module mxu_row_drain #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int ACC_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic [ROWS*COLS*ACC_W-1:0]    in_data,
  input  logic                          in_relu,
  input  logic                          in_pool2,
  input  logic                          clr,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [COLS*ACC_W-1:0]         out_wide_data,
  output logic [COLS*8-1:0]             out_int8_data,
  output logic [$clog2(ROWS)-1:0]       out_row_idx,
  output logic                          out_last,
  output logic                          busy
);

  localparam int RW    = $clog2(ROWS);
  localparam int ROW_W = COLS * ACC_W;

  // Index of the final beat for each mode.
  localparam logic [RW-1:0] LAST_FULL = RW'(ROWS - 1);
  localparam logic [RW-1:0] LAST_POOL = RW'(ROWS / 2 - 1);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                        state_q;
  logic [ROWS*COLS*ACC_W-1:0]    tile_q;
  logic                          relu_q;
  logic                          pool_q;
  logic [RW-1:0]                 cnt_q;
  logic                          out_vld_q;
  logic                          in_rdy_q;
  logic                          busy_q;

  logic [RW-1:0]                 cnt_last_d;
  logic                          beat_done_d;
  logic [RW-1:0]                 sel_a_d;
  logic [RW-1:0]                 sel_b_d;
  logic [ROW_W-1:0]              row_a_d;
  logic [ROW_W-1:0]              row_b_d;
  logic [ROW_W-1:0]              tile_rows [ROWS];

  assign cnt_last_d  = pool_q ? LAST_POOL : LAST_FULL;
  assign beat_done_d = out_vld_q & out_rdy;

  // ---------------------------------------------------------------------------
  // Control FSM. All handshake outputs are registered alongside the state so
  // they change only on the clock edge (or asynchronously on rst).
  // clr is checked before any capture or beat bookkeeping, so it wins over
  // both; a beat completing in the clr cycle has already been taken by the
  // consumer, so nothing needs to be undone.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tile_q    <= '0;
      relu_q    <= 1'b0;
      pool_q    <= 1'b0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else if (clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_vld) begin
            tile_q    <= in_data;
            relu_q    <= in_relu;
            pool_q    <= in_pool2;
            cnt_q     <= '0;
            state_q   <= S_DRAIN;
            out_vld_q <= 1'b1;
            in_rdy_q  <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (beat_done_d) begin
            if (cnt_q == cnt_last_d) begin
              // Counter returns to 0 here instead of wrapping past the tile.
              state_q   <= S_IDLE;
              cnt_q     <= '0;
              out_vld_q <= 1'b0;
              in_rdy_q  <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + RW'(1);
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          out_vld_q <= 1'b0;
          in_rdy_q  <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign in_rdy      = in_rdy_q;
  assign busy        = busy_q;
  assign out_vld     = out_vld_q;
  assign out_row_idx = cnt_q;
  assign out_last    = out_vld_q && (cnt_q == cnt_last_d);

  // ---------------------------------------------------------------------------
  // Row selection. In pool mode beat k reads rows 2k and 2k+1; otherwise row k
  // is routed through the A path and the B path is ignored.
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign tile_rows[r] = tile_q[r*ROW_W +: ROW_W];
  end

  assign sel_a_d = pool_q ? (cnt_q << 1) : cnt_q;
  assign sel_b_d = sel_a_d | RW'(1);
  assign row_a_d = tile_rows[sel_a_d];
  assign row_b_d = tile_rows[sel_b_d];

  // ---------------------------------------------------------------------------
  // Per-element datapath: ReLU first, then the optional pair max, then
  // saturation. Data outputs are forced to 0 whenever no beat is presented.
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic signed [ACC_W-1:0] a_raw;
    logic signed [ACC_W-1:0] b_raw;
    logic signed [ACC_W-1:0] a_act;
    logic signed [ACC_W-1:0] b_act;
    logic signed [ACC_W-1:0] elem;
    logic        [7:0]       elem_sat;

    assign a_raw = row_a_d[c*ACC_W +: ACC_W];
    assign b_raw = row_b_d[c*ACC_W +: ACC_W];

    assign a_act = (relu_q && a_raw[ACC_W-1]) ? '0 : a_raw;
    assign b_act = (relu_q && b_raw[ACC_W-1]) ? '0 : b_raw;

    assign elem = (pool_q && (b_act > a_act)) ? b_act : a_act;

    assign elem_sat = (elem > SAT_HI) ? 8'h7F :
                      (elem < SAT_LO) ? 8'h80 :
                      elem[7:0];

    assign out_wide_data[c*ACC_W +: ACC_W] = out_vld_q ? elem     : '0;
    assign out_int8_data[c*8 +: 8]         = out_vld_q ? elem_sat : 8'h00;
  end

endmodule

// File: tb/tb_mxu_row_drain.sv
module tb_mxu_row_drain;

  localparam int ROWS  = 4;
  localparam int COLS  = 2;
  localparam int ACC_W = 16;

  logic                       clk;
  logic                       rst;
  logic                       in_vld;
  logic                       in_rdy;
  logic [ROWS*COLS*ACC_W-1:0] in_data;
  logic                       in_relu;
  logic                       in_pool2;
  logic                       clr;
  logic                       out_vld;
  logic                       out_rdy;
  logic [COLS*ACC_W-1:0]      out_wide_data;
  logic [COLS*8-1:0]          out_int8_data;
  logic [1:0]                 out_row_idx;
  logic                       out_last;
  logic                       busy;

  mxu_row_drain #(.ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_vld        (in_vld),
    .in_rdy        (in_rdy),
    .in_data       (in_data),
    .in_relu       (in_relu),
    .in_pool2      (in_pool2),
    .clr           (clr),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .out_wide_data (out_wide_data),
    .out_int8_data (out_int8_data),
    .out_row_idx   (out_row_idx),
    .out_last      (out_last),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] wide;
    logic [15:0] i8;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int w0, input int w1, input int i0, input int i1,
                      input int idx, input bit last);
    beat_t b;
    b.wide = {16'(w1), 16'(w0)};
    b.i8   = {8'(i1), 8'(i0)};
    b.idx  = 2'(idx);
    b.last = last;
    exp_q.push_back(b);
  endtask

  function automatic logic [127:0] mk_tile(input int v0, input int v1, input int v2, input int v3,
                                           input int v4, input int v5, input int v6, input int v7);
    logic [127:0] t;
    int v[8];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7};
    for (int i = 0; i < 8; i++) t[i*16 +: 16] = 16'(v[i]);
    return t;
  endfunction

  // Monitor: pops the scoreboard on every completed beat, checks that stalled
  // beats hold, and that idle outputs are zero.
  beat_t hold_snap;
  bit    hold_pend = 0;

  always @(negedge clk) begin
    beat_t act;
    act = {out_wide_data, out_int8_data, out_row_idx, out_last};
    if (rst) begin
      hold_pend = 0;
    end else begin
      if (hold_pend) begin
        chk("stall_hold", {out_vld, act}, {1'b1, hold_snap});
        hold_pend = 0;
      end
      if (out_vld) begin
        if (!out_rdy) begin
          hold_snap = act;
          hold_pend = 1;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", act);
        end else begin
          chk("beat", act, exp_q.pop_front());
        end
      end else begin
        chk("idle_zero", {out_wide_data, out_int8_data, out_last}, '0);
      end
    end
  end

  task automatic send(input logic [127:0] t, input bit relu, input bit pool);
    int n;
    in_data  = t;
    in_relu  = relu;
    in_pool2 = pool;
    in_vld   = 1'b1;
    n = 0;
    while (!in_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_rdy) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    chk("first_beat_latency", out_vld, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(in_rdy && exp_q.size() == 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", {in_rdy, 32'(exp_q.size())}, {1'b1, 32'd0});
  endtask

  task automatic push_plain1234();
    push(1, 2, 1, 2, 0, 0);
    push(3, 4, 3, 4, 1, 0);
    push(5, 6, 5, 6, 2, 0);
    push(7, 8, 7, 8, 3, 1);
  endtask

  logic [127:0] t_plain, t_sat, t_pool, t_pool_relu, t_y;

  initial begin
    t_plain     = mk_tile(1, 2, 3, 4, 5, 6, 7, 8);
    t_sat       = mk_tile(300, -200, -1, 127, 128, -129, -128, 0);
    t_pool      = mk_tile(-5, 9, 4, -1, 0, 0, -3, -7);
    t_pool_relu = mk_tile(-5, -9, -4, 200, -300, 7, 6, -2);
    t_y         = mk_tile(10, -10, 20, -20, 30, -30, 40, -40);

    rst = 1'b1; in_vld = 0; in_data = '0; in_relu = 0; in_pool2 = 0;
    clr = 0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held", {in_rdy, busy, out_vld, out_last, out_row_idx, out_wide_data, out_int8_data},
        {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 16'd0});
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_released", {in_rdy, busy, out_vld, out_last, out_row_idx, out_wide_data, out_int8_data},
        {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 16'd0});

    // Plain tile, consecutive beats; pool2 toggled during drain must be ignored.
    push_plain1234();
    send(t_plain, 0, 0);
    in_pool2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("plain_vld", out_vld, 1);
      chk("plain_idx", out_row_idx, k);
      @(posedge clk); #1;
    end
    chk("plain_after", {in_rdy, out_vld, busy}, {1'b1, 1'b0, 1'b0});
    wait_drain();

    // Saturation, relu off (relu toggled during drain must be ignored).
    push(300, -200, 127, -128, 0, 0);
    push(-1, 127, -1, 127, 1, 0);
    push(128, -129, 127, -128, 2, 0);
    push(-128, 0, -128, 0, 3, 1);
    send(t_sat, 0, 0);
    in_relu = 1'b1;
    wait_drain();

    // Saturation, relu on.
    push(300, 0, 127, 0, 0, 0);
    push(0, 127, 0, 127, 1, 0);
    push(128, 0, 127, 0, 2, 0);
    push(0, 0, 0, 0, 3, 1);
    send(t_sat, 1, 0);
    wait_drain();

    // Pool2, relu off.
    push(4, 9, 4, 9, 0, 0);
    push(0, 0, 0, 0, 1, 1);
    send(t_pool, 0, 1);
    wait_drain();

    // Pool2 with relu: relu applied before the max.
    push(0, 200, 0, 127, 0, 0);
    push(6, 7, 6, 7, 1, 1);
    send(t_pool_relu, 1, 1);
    wait_drain();

    // Back-pressure: out_rdy 1,0,0,1 -> beat 1 held for three cycles.
    push_plain1234();
    out_rdy = 1'b1;
    send(t_plain, 0, 0);
    @(posedge clk); #1;
    chk("stall_idx_c1", {out_vld, out_row_idx}, {1'b1, 2'd1});
    out_rdy = 1'b0;
    @(posedge clk); #1;
    chk("stall_idx_c2", {out_vld, out_row_idx}, {1'b1, 2'd1});
    @(posedge clk); #1;
    chk("stall_idx_c3", {out_vld, out_row_idx}, {1'b1, 2'd1});
    out_rdy = 1'b1;
    wait_drain();

    // clr at beat 2 (beat 2 still transferred), then clr with a capture offered.
    push(1, 2, 1, 2, 0, 0);
    push(3, 4, 3, 4, 1, 0);
    push(5, 6, 5, 6, 2, 0);
    send(t_plain, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("clr_at_idx", out_row_idx, 2);
    clr = 1'b1;
    in_data = t_sat;
    in_vld = 1'b1;
    @(posedge clk); #1;
    chk("clr_next", {out_vld, busy, in_rdy, out_row_idx}, {1'b0, 1'b0, 1'b1, 2'd0});
    @(posedge clk); #1;
    chk("clr_capture_discarded", {out_vld, busy, in_rdy}, {1'b0, 1'b0, 1'b1});
    clr = 1'b0;
    in_vld = 1'b0;
    push(10, -10, 10, -10, 0, 0);
    push(20, -20, 20, -20, 1, 0);
    push(30, -30, 30, -30, 2, 0);
    push(40, -40, 40, -40, 3, 1);
    send(t_y, 0, 0);
    wait_drain();

    // Asynchronous reset mid-drain.
    out_rdy = 1'b0;
    send(t_plain, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst", {in_rdy, busy, out_vld, out_last, out_row_idx, out_wide_data, out_int8_data},
        {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 16'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    out_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("no_beat_after_rst", {out_vld, busy}, {1'b0, 1'b0});
    end

    // Recovery after reset.
    push(10, -10, 10, -10, 0, 0);
    push(20, -20, 20, -20, 1, 0);
    push(30, -30, 30, -30, 2, 0);
    push(40, -40, 40, -40, 3, 1);
    send(t_y, 0, 0);
    wait_drain();

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
